// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bus of the physical register free list.
// The rename stage owns the master side; the free list is the slave.
interface phys_reg_free_list_if #(
  parameter int NUM_CKPT = 4
);
  localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [1:0]    alloc_req;
  logic          ext_stall;
  logic [1:0]    alloc_valid;
  logic [5:0]    alloc_addr [2];
  logic          alloc_stall;
  logic [1:0]    free_valid;
  logic [5:0]    free_addr [2];
  logic          ckpt_take;
  logic [CW-1:0] ckpt_id;
  logic          if_recall;
  logic [CW-1:0] recall_id;
  logic [6:0]    free_count;
  logic          overflow_err;

  modport master (
    output alloc_req, ext_stall, free_valid, free_addr,
           ckpt_take, ckpt_id, if_recall, recall_id,
    input  alloc_valid, alloc_addr, alloc_stall, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, ext_stall, free_valid, free_addr,
           ckpt_take, ckpt_id, if_recall, recall_id,
    output alloc_valid, alloc_addr, alloc_stall, free_count, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of 64 physical registers: two-lane zero-latency allocation,
// two-lane commit-time release, and head-pointer checkpoints for branch recovery.
module phys_reg_free_list #(
  parameter int NUM_CKPT = 4
) (
  input logic                 clk,
  input logic                 reset,
  phys_reg_free_list_if.slave bus
);
  localparam int CW    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  localparam int DEPTH = 64;

  logic [5:0] list_data [DEPTH];
  logic [6:0] ckpt_data [NUM_CKPT];
  logic [6:0] head_reg, head_next;
  logic [6:0] tail_reg, tail_next;
  logic       overflow_reg, overflow_next;
  logic [6:0] count;
  logic [1:0] n_req, n_grant, grant;
  logic       grant_ok;
  logic [5:0] rd_idx1;
  logic [1:0] keep, accept;
  logic [6:0] count_after0;
  logic [5:0] wr_idx [2];

  // Allocation: all-or-nothing grant against the current free count (no bypass of frees).
  always_comb begin
    count    = tail_reg - head_reg;
    n_req    = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    grant_ok = count >= {5'd0, n_req};
    grant    = bus.alloc_req & {2{grant_ok}};
    n_grant  = {1'b0, grant[0]} + {1'b0, grant[1]};
    rd_idx1  = head_reg[5:0] + {5'd0, grant[0]};
  end

  // Release: capacity is measured against this cycle's count, lane 0 claiming first.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      keep[i] = bus.free_valid[i] && (bus.free_addr[i] != 6'd0);
    end
    accept[0]     = keep[0] && (count < 7'd64);
    count_after0  = count + {6'd0, accept[0]};
    accept[1]     = keep[1] && (count_after0 < 7'd64);
    wr_idx[0]     = tail_reg[5:0];
    wr_idx[1]     = tail_reg[5:0] + {5'd0, accept[0]};
    tail_next     = tail_reg + {6'd0, accept[0]} + {6'd0, accept[1]};
    overflow_next = overflow_reg | (keep[0] & ~accept[0]) | (keep[1] & ~accept[1]);
  end

  always_comb begin
    if (bus.if_recall) begin
      head_next = ckpt_data[bus.recall_id];
    end else if (bus.ext_stall) begin
      head_next = head_reg;
    end else begin
      head_next = head_reg + {5'd0, n_grant};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg     <= 7'd0;
      tail_reg     <= 7'd32;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      overflow_reg <= overflow_next;
    end
  end

  // Entries 0..31 start holding registers 32..63; the rest are empty until freed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_list
    localparam logic [5:0] INIT = (gi < 32) ? 6'(32 + gi) : 6'd0;
    logic [5:0] entry_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_reg <= INIT;
      end else if (accept[1] && (wr_idx[1] == 6'(gi))) begin
        entry_reg <= bus.free_addr[1];
      end else if (accept[0] && (wr_idx[0] == 6'(gi))) begin
        entry_reg <= bus.free_addr[0];
      end
    end
    assign list_data[gi] = entry_reg;
  end

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ckpt
    logic [6:0] slot_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_reg <= 7'd0;
      end else if (bus.ckpt_take && !bus.if_recall && (bus.ckpt_id == CW'(gi))) begin
        slot_reg <= head_next;
      end
    end
    assign ckpt_data[gi] = slot_reg;
  end

  assign bus.alloc_valid   = grant;
  assign bus.alloc_addr[0] = list_data[head_reg[5:0]];
  assign bus.alloc_addr[1] = list_data[rd_idx1];
  assign bus.alloc_stall   = ~grant_ok;
  assign bus.free_count    = count;
  assign bus.overflow_err  = overflow_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a list model.
module tb_phys_reg_free_list;
  localparam int NUM_CKPT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.NUM_CKPT(NUM_CKPT)) bus ();
  phys_reg_free_list #(.NUM_CKPT(NUM_CKPT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  // Model state: register numbers in list order, pointers as plain integers mod 128.
  int m_list [64];
  int m_head, m_tail;
  int m_ckpt [NUM_CKPT];
  bit m_ovf;
  int m_ngrant;

  // Current stimulus.
  bit [1:0] i_req, i_fv;
  bit       i_stall, i_ct, i_rc;
  int       i_fa [2];
  int       i_cid, i_rid;

  // Expected outputs for the current cycle.
  bit [1:0] exp_valid;
  int       exp_addr [2];
  bit       exp_stall;
  int       exp_count;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_count();
    return (m_tail - m_head + 128) % 128;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) m_list[k] = (k < 32) ? 32 + k : 0;
    m_head = 0;
    m_tail = 32;
    for (int k = 0; k < NUM_CKPT; k++) m_ckpt[k] = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_eval();
    int cnt, nreq, ptr;
    cnt  = model_count();
    nreq = int'(i_req[0]) + int'(i_req[1]);
    ptr  = m_head;
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = i_req[i] && (cnt >= nreq);
      exp_addr[i]  = m_list[ptr % 64];
      if (exp_valid[i]) ptr++;
    end
    m_ngrant  = ptr - m_head;
    exp_stall = (cnt < nreq);
    exp_count = cnt;
  endtask

  task automatic model_step();
    int cnt, nh;
    cnt = model_count();
    for (int i = 0; i < 2; i++) begin
      if (i_fv[i] && i_fa[i] != 0) begin
        if (cnt < 64) begin
          m_list[m_tail % 64] = i_fa[i];
          m_tail = (m_tail + 1) % 128;
          cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (i_rc) begin
      m_head = m_ckpt[i_rid];
    end else begin
      nh = i_stall ? m_head : (m_head + m_ngrant) % 128;
      if (i_ct) m_ckpt[i_cid] = nh;
      m_head = nh;
    end
  endtask

  task automatic drive(bit [1:0] req, bit stall, bit [1:0] fv, int fa0, int fa1,
                       bit ct, int cid, bit rc, int rid);
    i_req = req; i_stall = stall; i_fv = fv; i_fa[0] = fa0; i_fa[1] = fa1;
    i_ct = ct; i_cid = cid; i_rc = rc; i_rid = rid;
    bus.alloc_req    = req;
    bus.ext_stall    = stall;
    bus.free_valid   = fv;
    bus.free_addr[0] = 6'(fa0);
    bus.free_addr[1] = 6'(fa1);
    bus.ckpt_take    = ct;
    bus.ckpt_id      = 2'(cid);
    bus.if_recall    = rc;
    bus.recall_id    = 2'(rid);
    model_eval();
    check_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    check_en = 1'b0;
    idle();
    check_en = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    idle();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      $display("cyc=%0d req=%b grant=%b addr=%0d/%0d stall=%b cnt=%0d ovf=%b",
               cyc, bus.alloc_req, bus.alloc_valid, bus.alloc_addr[0], bus.alloc_addr[1],
               bus.alloc_stall, bus.free_count, bus.overflow_err);
      chk("alloc_valid", 32'(bus.alloc_valid), 32'(exp_valid));
      chk("alloc_addr0", 32'(bus.alloc_addr[0]), 32'(exp_addr[0]));
      chk("alloc_addr1", 32'(bus.alloc_addr[1]), 32'(exp_addr[1]));
      chk("alloc_stall", 32'(bus.alloc_stall), 32'(exp_stall));
      chk("free_count", 32'(bus.free_count), 32'(exp_count));
      chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    end
  end

  initial begin
    bit [1:0] req, fv;
    bit       stall, ct, rc;
    int       fa0, fa1, cid, rid;
    bit       ckpt_ok [NUM_CKPT];

    reset = 1'b1;
    model_reset();
    idle();
    check_en = 1'b0;
    #11;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Post-reset state.
    idle();
    chk("rst free_count", 32'(bus.free_count), 32'd32);
    chk("rst alloc_stall", 32'(bus.alloc_stall), 32'd0);
    chk("rst alloc_valid", 32'(bus.alloc_valid), 32'd0);
    chk("rst alloc_addr0", 32'(bus.alloc_addr[0]), 32'd32);
    chk("rst overflow_err", 32'(bus.overflow_err), 32'd0);

    // Two-lane grant.
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("dual valid", 32'(bus.alloc_valid), 32'd3);
    chk("dual addr0", 32'(bus.alloc_addr[0]), 32'd32);
    chk("dual addr1", 32'(bus.alloc_addr[1]), 32'd33);
    step();
    idle();
    chk("dual count", 32'(bus.free_count), 32'd30);

    // Lane 1 alone takes the head entry.
    do_reset();
    drive(2'b10, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("lane1 valid", 32'(bus.alloc_valid), 32'd2);
    chk("lane1 addr1", 32'(bus.alloc_addr[1]), 32'd32);
    step();
    idle();
    chk("lane1 count", 32'(bus.free_count), 32'd31);

    // ext_stall freezes head even though the grant is shown.
    do_reset();
    drive(2'b11, 1'b1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("xstall valid", 32'(bus.alloc_valid), 32'd3);
    step();
    idle();
    chk("xstall count", 32'(bus.free_count), 32'd32);
    chk("xstall addr0", 32'(bus.alloc_addr[0]), 32'd32);

    // Exhaustion: a same-cycle free is not bypassed.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
      step();
    end
    drive(2'b01, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    drive(2'b11, 1'b0, 2'b01, 5, 0, 1'b0, 0, 1'b0, 0);
    chk("exh stall", 32'(bus.alloc_stall), 32'd1);
    chk("exh valid", 32'(bus.alloc_valid), 32'd0);
    chk("exh count", 32'(bus.free_count), 32'd1);
    step();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("exh2 valid", 32'(bus.alloc_valid), 32'd3);
    chk("exh2 addr0", 32'(bus.alloc_addr[0]), 32'd63);
    chk("exh2 addr1", 32'(bus.alloc_addr[1]), 32'd5);
    step();
    idle();
    chk("exh empty", 32'(bus.free_count), 32'd0);

    // Checkpoint then recall.
    do_reset();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b1, 2, 1'b0, 0);
    step();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    idle();
    chk("pre recall count", 32'(bus.free_count), 32'd26);
    drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b1, 2);
    step();
    drive(2'b01, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    chk("recall count", 32'(bus.free_count), 32'd30);
    chk("recall addr0", 32'(bus.alloc_addr[0]), 32'd34);

    // Recall overrides allocation; the free still lands at the tail.
    do_reset();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b1, 1, 1'b0, 0);
    step();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    drive(2'b11, 1'b0, 2'b01, 7, 0, 1'b0, 0, 1'b1, 1);
    step();
    idle();
    chk("rcfree count", 32'(bus.free_count), 32'd31);
    chk("rcfree addr0", 32'(bus.alloc_addr[0]), 32'd34);

    // Overflow and x0 filtering.
    do_reset();
    drive(2'b00, 1'b0, 2'b11, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    idle();
    chk("x0 count", 32'(bus.free_count), 32'd32);
    for (int k = 0; k < 32; k++) begin
      drive(2'b00, 1'b0, 2'b01, k + 1, 0, 1'b0, 0, 1'b0, 0);
      step();
    end
    idle();
    chk("full count", 32'(bus.free_count), 32'd64);
    chk("full no ovf", 32'(bus.overflow_err), 32'd0);
    drive(2'b00, 1'b0, 2'b01, 40, 0, 1'b0, 0, 1'b0, 0);
    step();
    idle();
    chk("ovf set", 32'(bus.overflow_err), 32'd1);
    chk("ovf count", 32'(bus.free_count), 32'd64);
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    step();
    idle();
    chk("ovf sticky", 32'(bus.overflow_err), 32'd1);

    // Randomized traffic with a mid-operation asynchronous reset.
    do_reset();
    for (int k = 0; k < NUM_CKPT; k++) ckpt_ok[k] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      req   = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 7) == 0);
      fv    = {($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1)};
      fa0   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      fa1   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      ct    = ($urandom_range(0, 5) == 0);
      cid   = int'($urandom_range(0, NUM_CKPT - 1));
      rid   = int'($urandom_range(0, NUM_CKPT - 1));
      rc    = ($urandom_range(0, 11) == 0) && ckpt_ok[rid];
      drive(req, stall, fv, fa0, fa1, ct, cid, rc, rid);
      if (c == 700) begin
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("async rst count", 32'(bus.free_count), 32'd32);
        chk("async rst addr0", 32'(bus.alloc_addr[0]), 32'd32);
        chk("async rst ovf", 32'(bus.overflow_err), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < NUM_CKPT; k++) ckpt_ok[k] = 1'b0;
        cyc++;
      end else begin
        step();
        if (rc) begin
          for (int k = 0; k < NUM_CKPT; k++) ckpt_ok[k] = 1'b0;
        end else if (ct) begin
          ckpt_ok[cid] = 1'b1;
        end
      end
    end

    idle();
    check_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have parameter NUM_CKPT, default 4, number of head-pointer checkpoints.
REQ-002 SHALL have port clk, input, 1, the only clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset; clears all state immediately.
REQ-004 SHALL have port alloc_req[2], input, 1 each, rename lane i needs one physical register.
REQ-005 SHALL have port ext_stall, input, 1, freezes allocation pointer advance.
REQ-006 SHALL have port alloc_valid[2], output, 1 each, lane i granted this cycle.
REQ-007 SHALL have port alloc_addr[2], output, 6 each, granted physical register.
REQ-008 SHALL have port alloc_stall, output, 1, insufficient free registers for all requests.
REQ-009 SHALL have port free_valid[2], input, 1 each, commit returns old physical register.
REQ-010 SHALL have port free_addr[2], input, 6 each, register being returned.
REQ-011 SHALL have port ckpt_take, input, 1, snapshot head pointer at branch rename.
REQ-012 SHALL have port ckpt_id, input, $clog2(NUM_CKPT), checkpoint slot written.
REQ-013 SHALL have port if_recall, input, 1, mispredict restore.
REQ-014 SHALL have port recall_id, input, $clog2(NUM_CKPT), checkpoint slot restored.
REQ-015 SHALL have port free_count, output, 7, registers currently allocatable (0..64).
REQ-016 SHALL have port overflow_err, output, 1, sticky: more than 64 free entries attempted.

Function
REQ-017 SHALL store a 64-entry circular list of 6-bit register numbers with 7-bit head and tail pointers (bit 6 = wrap); free_count = tail - head mod 128.
REQ-018 SHALL compute n_req = alloc_req[0] + alloc_req[1] combinationally; grant all iff free_count >= n_req, else grant none and assert alloc_stall.
REQ-019 SHALL give the lowest requesting lane list[head] and a second requesting lane list[head+1]; alloc_addr of a non-granted lane = list[head + lower-lane grants], alloc_valid = 0.
REQ-020 SHALL allocate with zero latency: alloc_valid/alloc_addr valid in the request cycle; head advances by n_granted at the next edge only if ~ext_stall and ~if_recall.
REQ-021 SHALL append free_valid lanes at tail in lane order (lane 0 first) every cycle regardless of ext_stall or if_recall; tail advances by the accepted count.
REQ-022 SHALL ignore free_valid with free_addr == 0 (x0 mapping never recycled).
REQ-023 SHALL, on ckpt_take without if_recall, store into slot ckpt_id the head value after this cycle's allocation (post-advance value, ext_stall respected).
REQ-024 SHALL, on if_recall, load head from slot recall_id at the next edge; recall overrides allocation and ckpt_take in that cycle; tail is not rewound.
REQ-025 SHALL, same cycle free and alloc with free_count < n_req, not use registers being freed that cycle (no bypass).
REQ-026 SHALL set overflow_err if a tail advance would make free_count exceed 64; the excess entry is dropped, overflow_err holds until reset.
REQ-027 SHALL treat pointer wrap from 127 to 0 and entry index wrap 63 to 0 seamlessly.

Reset
REQ-028 SHALL on reset set list[k] = 32+k for k = 0..31, list[k] = 0 for k = 32..63, head = 0, tail = 32, all checkpoints = 0, overflow_err = 0.
REQ-029 SHALL therefore present after reset free_count = 32, alloc_stall = 0, alloc_valid = 0 with no request, alloc_addr[0] = 32.
REQ-030 SHALL apply reset asserted mid-operation asynchronously, discarding any in-flight allocation, free, or recall.

Verification
REQ-031 Reset, alloc_req = {1,1} one cycle -> alloc_addr = {32,33} valid; next cycle free_count = 30.
REQ-032 Only alloc_req[1] = 1 after reset -> lane 1 gets 32, alloc_valid = {0,1}; free_count = 31 next cycle.
REQ-033 Allocate 31 registers, then alloc_req = {1,1} -> alloc_stall = 1, no grant, head unchanged; with free_valid[0] = 1, addr 5 same cycle -> still stalled, next cycle grant {63,5}.
REQ-034 Reset, ckpt_take id 2 with alloc {1,1}, then allocate 4 more, then if_recall id 2 -> head = 2, free_count = 30, next alloc returns 34.
REQ-035 if_recall with alloc_req = {1,1} and free_valid[0] = 1 addr 7 same cycle -> head = checkpoint, tail + 1, list tail slot = 7.
REQ-036 Free 33 non-zero registers after reset with no allocation -> overflow_err = 1 on the 33rd, free_count stays 64; free_addr = 0 never changes free_count.
